branch_sequencer: RTL
=====================

# branch_sequencer

Sequences the program counter for the KGP_RISC core. Accepts one decoded instruction at a time, waits for the ALU when the instruction needs it, and keeps the registered carry flag. It resolves the 3-bit branch code against ALU sign/zero and the stored carry, then drives the next PC, a one-cycle fetch flush on taken branches, and the link write for calls. It sits between decode and fetch, wrapping the combinational branch-condition logic with state.

## Interface
- ADDR_W, 32, PC and target width
- RESET_PC, 0, PC value after reset
- PC_STEP, 4, sequential PC increment
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- dec_valid  in  1  decoded instruction offered
- dec_ready  out  1  sequencer can accept (handshake completes when both high)
- dec_branch  in  3  000 none, 001 br, 010 call, 011 sign&!zero, 100 zero, 101 !zero, 110 carry, 111 !carry
- dec_target  in  ADDR_W  branch target
- dec_sets_flags  in  1  instruction updates the carry flag
- dec_uses_alu  in  1  instruction issues an ALU operation
- alu_done  in  1  ALU result and flags valid this cycle
- alu_carry, alu_zero, alu_sign  in  1 each  ALU flags, qualified by alu_done
- pc  out  ADDR_W  current PC, registered
- flush  out  1  fetch flush, registered, one cycle per taken branch
- link_we  out  1  link-register write strobe, registered, one cycle
- link_addr  out  ADDR_W  return address, valid when link_we
- carry_flag  out  1  stored carry

## Operation
- States: IDLE, WAIT_ALU, FLUSH. Reset: state IDLE, pc=RESET_PC, carry_flag=0, flush=0, link_we=0, link_addr=0. dec_ready=1 only in IDLE.
- On accept in IDLE, capture dec_branch, dec_target, dec_sets_flags, and pc+PC_STEP.
- Codes 001 or 010 with dec_uses_alu=0: pc<=target, flush<=1, go to FLUSH. For 010, also link_we<=1 and link_addr<=pc+PC_STEP.
- Code 000 with dec_uses_alu=0: pc<=pc+PC_STEP and stay in IDLE (back-to-back accepts allowed).
- Otherwise, go to WAIT_ALU. Conditional codes 011–111 always wait for the ALU.
- WAIT_ALU: stay until alu_done. On alu_done:
  - If captured sets_flags, carry_flag<=alu_carry.
  - Evaluate the condition: 011/100/101 use live alu_sign/alu_zero. 110/111 use carry_flag as it was before this update; the branch never tests its own flag write.
  - Taken: pc<=target, flush<=1, link as above for 010, go to FLUSH.
  - Not taken or 000: pc<=pc+PC_STEP, return to IDLE.
- FLUSH: one cycle with dec_ready=0. flush and link_we drop. Return to IDLE.
- alu_done outside WAIT_ALU is ignored. dec_valid while dec_ready=0 is not captured; decode holds it.
- PC arithmetic is modulo 2^ADDR_W; pc+PC_STEP wraps silently.
- rst_n low in any state aborts immediately to reset values. A pending ALU result is discarded.

## Timing
- Non-ALU sequential instruction: pc updates at the accept edge. Throughput 1/cycle.
- Non-ALU taken branch: pc at the accept edge, flush/link high for the next cycle, dec_ready high again 1 cycle after that. Throughput 1 per 2 cycles.
- ALU instruction: pc updates at the alu_done edge. Taken adds one FLUSH cycle.
- The ALU path has zero extra latency beyond alu_done; alu_done in the cycle right after accept is legal.

## Structure
- Shared package kgp_risc_pkg holds:
  - branch-code localparams BR_NONE, BR_JMP, BR_CALL, BR_LTZ, BR_Z, BR_NZ, BR_C, BR_NC
  - the sequencer state enum
  - default PC_STEP
- One sub-module, cond_eval: purely combinational (code, carry, zero, sign) -> taken. It is instantiated once and fed the live or stored flags per the rules above.

## Test plan
- Reset release: pc=0, dec_ready=1, flush=0, carry_flag=0. Three 000 non-ALU accepts give pc 4, 8, 12 on consecutive cycles.
- Call 010 to 0x100 at pc=0x20, non-ALU: next cycle pc=0x100, flush=1, link_we=1, link_addr=0x24. dec_ready=0 for one cycle.
- Flag-setting ALU op with alu_carry=1 after a 3-cycle alu_done delay: carry_flag=1, pc+=4. A following 110 with ALU done jumps to its target; a 111 falls through.
- Code 011: alu_sign=1,zero=0 taken. alu_sign=1,zero=1 not taken (pc+4, no flush). 100/101 checked with zero=1 and zero=0.
- rst_n asserted while in WAIT_ALU, then a late alu_done: outputs at reset values, the alu_done is ignored, carry_flag stays 0.
- pc=0xFFFFFFFC with a 000 instruction: pc wraps to 0. A taken branch with dec_valid held high during FLUSH captures the held instruction only on the following cycle.

Source files
------------

// File: rtl/kgp_risc_pkg.sv
// Shared KGP_RISC definitions: branch codes, sequencer states and the
// default sequential PC increment.
package kgp_risc_pkg;

  localparam logic [2:0] BR_NONE = 3'b000;
  localparam logic [2:0] BR_JMP  = 3'b001;
  localparam logic [2:0] BR_CALL = 3'b010;
  localparam logic [2:0] BR_LTZ  = 3'b011;
  localparam logic [2:0] BR_Z    = 3'b100;
  localparam logic [2:0] BR_NZ   = 3'b101;
  localparam logic [2:0] BR_C    = 3'b110;
  localparam logic [2:0] BR_NC   = 3'b111;

  localparam int PC_STEP_DEFAULT = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_ALU,
    S_FLUSH
  } seq_state_t;

endpackage

// File: rtl/branch_sequencer_cond_eval.sv
// Combinational branch-condition resolver: maps a 3-bit branch code and
// the carry/zero/sign flags to a taken decision.
module cond_eval
  import kgp_risc_pkg::*;
(
  input  logic [2:0] code,
  input  logic       carry,
  input  logic       zero,
  input  logic       sign,
  output logic       taken
);

  always_comb begin
    case (code)
      BR_NONE: taken = 1'b0;
      BR_JMP:  taken = 1'b1;
      BR_CALL: taken = 1'b1;
      BR_LTZ:  taken = sign & ~zero;
      BR_Z:    taken = zero;
      BR_NZ:   taken = ~zero;
      BR_C:    taken = carry;
      BR_NC:   taken = ~carry;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_sequencer.sv
// PC sequencer between decode and fetch: accepts one decoded instruction,
// waits for the ALU when needed, resolves branches and drives flush/link.
module branch_sequencer
  import kgp_risc_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                PC_STEP  = PC_STEP_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dec_valid,
  output logic              dec_ready,
  input  logic [2:0]        dec_branch,
  input  logic [ADDR_W-1:0] dec_target,
  input  logic              dec_sets_flags,
  input  logic              dec_uses_alu,
  input  logic              alu_done,
  input  logic              alu_carry,
  input  logic              alu_zero,
  input  logic              alu_sign,
  output logic [ADDR_W-1:0] pc,
  output logic              flush,
  output logic              link_we,
  output logic [ADDR_W-1:0] link_addr,
  output logic              carry_flag
);

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

  seq_state_t        state_q, state_d;
  logic [ADDR_W-1:0] pc_d, link_addr_d;
  logic              carry_d, flush_d, link_we_d;

  // Instruction captured at accept, consumed when the ALU reports done.
  logic [2:0]        br_q, br_d;
  logic [ADDR_W-1:0] tgt_q, tgt_d;
  logic [ADDR_W-1:0] ret_q, ret_d;
  logic              sets_q, sets_d;

  logic [ADDR_W-1:0] pc_plus;
  logic              taken;

  assign pc_plus   = pc + STEP;
  assign dec_ready = (state_q == S_IDLE);

  // Carry input is the stored flag, so 110/111 never see the ALU op's own
  // carry write; sign/zero are the live ALU flags.
  cond_eval u_cond_eval (
    .code  (br_q),
    .carry (carry_flag),
    .zero  (alu_zero),
    .sign  (alu_sign),
    .taken (taken)
  );

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    state_d     = state_q;
    pc_d        = pc;
    carry_d     = carry_flag;
    flush_d     = 1'b0;
    link_we_d   = 1'b0;
    link_addr_d = link_addr;
    br_d        = br_q;
    tgt_d       = tgt_q;
    ret_d       = ret_q;
    sets_d      = sets_q;

    case (state_q)
      S_IDLE: begin
        if (dec_valid) begin
          br_d   = dec_branch;
          tgt_d  = dec_target;
          ret_d  = pc_plus;
          sets_d = dec_sets_flags;
          if (!dec_uses_alu && (dec_branch == BR_JMP || dec_branch == BR_CALL)) begin
            pc_d    = dec_target;
            flush_d = 1'b1;
            state_d = S_FLUSH;
            if (dec_branch == BR_CALL) begin
              link_we_d   = 1'b1;
              link_addr_d = pc_plus;
            end
          end else if (!dec_uses_alu && dec_branch == BR_NONE) begin
            pc_d = pc_plus;
          end else begin
            state_d = S_WAIT_ALU;
          end
        end
      end

      S_WAIT_ALU: begin
        if (alu_done) begin
          if (sets_q) carry_d = alu_carry;
          if (taken) begin
            pc_d    = tgt_q;
            flush_d = 1'b1;
            state_d = S_FLUSH;
            if (br_q == BR_CALL) begin
              link_we_d   = 1'b1;
              link_addr_d = ret_q;
            end
          end else begin
            pc_d    = ret_q;
            state_d = S_IDLE;
          end
        end
      end

      S_FLUSH: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop
  // samples the pre-edge values of the others, matching real hardware.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      pc         <= RESET_PC;
      carry_flag <= 1'b0;
      flush      <= 1'b0;
      link_we    <= 1'b0;
      link_addr  <= '0;
      br_q       <= BR_NONE;
      tgt_q      <= '0;
      ret_q      <= '0;
      sets_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc         <= pc_d;
      carry_flag <= carry_d;
      flush      <= flush_d;
      link_we    <= link_we_d;
      link_addr  <= link_addr_d;
      br_q       <= br_d;
      tgt_q      <= tgt_d;
      ret_q      <= ret_d;
      sets_q     <= sets_d;
    end
  end

endmodule
